// File: rtl/external_io_pkg.sv
// Shared types and helpers for the external I/O block.
// Imported by the SPI frame slave and the top level.
package external_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    TX   = 2'd2
  } spi_state_t;

  localparam int SYNC_STAGES_DEFAULT = 2;

  // Bits needed to hold values 0..v-1
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/external_io_v2_spi_slave_frame.sv
// SPI mode-0 slave, oversampled on clk, with length-checked frames.
// RX frames commit atomically; TX frames shift out a loaded word.
module spi_slave_frame
  import external_io_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit TX_EN       = 1'b0,
  parameter int TX_WIDTH    = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sck,
  input  logic                sdi,
  input  logic                cs_n,
  input  logic                tx_req,
  input  logic [TX_WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0]    rx_data,
  output logic                rx_commit,
  output logic                tx_done,
  output logic                frame_err,
  output logic                sdo,
  output logic                in_tx
);

  localparam int MAXW = (WIDTH > TX_WIDTH) ? WIDTH : TX_WIDTH;
  localparam int CW   = clog2(MAXW + 2);
  localparam logic [CW-1:0] RX_LEN = CW'(WIDTH);
  localparam logic [CW-1:0] RX_SAT = CW'(WIDTH + 1);
  localparam logic [CW-1:0] TX_LEN = CW'(TX_WIDTH);
  localparam logic [CW-1:0] TX_SAT = CW'(TX_WIDTH + 1);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic sck_hist_q, sck_hist_d;
  logic cs_hist_q, cs_hist_d;
  spi_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [TX_WIDTH-1:0] tx_q, tx_d;

  logic sck_s, sdi_s, cs_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  // Synchroniser chains plus one history flop for edge detection
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sck_s      = sck_sync_q[SYNC_STAGES-1];
    sdi_s      = sdi_sync_q[SYNC_STAGES-1];
    cs_s       = cs_sync_q[SYNC_STAGES-1];
    sck_hist_d = sck_s;
    cs_hist_d  = cs_s;
    sck_rise   = sck_s & ~sck_hist_q;
    sck_fall   = ~sck_s & sck_hist_q;
    cs_fall    = ~cs_s & cs_hist_q;
    cs_rise    = cs_s & ~cs_hist_q;
  end

  // Frame FSM: counter, RX shifter, TX shifter and end-of-frame strobes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    rx_commit = 1'b0;
    tx_done   = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          cnt_d = '0;
          if (TX_EN && tx_req) begin
            state_d = TX;
            tx_d    = tx_data;
          end else begin
            state_d = RX;
            sh_d    = '0;
          end
        end
      end
      RX: begin
        if (sck_rise) begin
          sh_d = {sh_q[WIDTH-2:0], sdi_s};
          if (cnt_q != RX_SAT) cnt_d = cnt_q + CW'(1);
        end
        if (cs_rise) begin
          state_d = IDLE;
          if (cnt_q == RX_LEN) rx_commit = 1'b1;
          else frame_err = 1'b1;
        end
      end
      TX: begin
        if (sck_fall) tx_d = tx_q << 1;
        if (sck_rise && cnt_q != TX_SAT) cnt_d = cnt_q + CW'(1);
        if (cs_rise) begin
          state_d = IDLE;
          if (cnt_q == TX_LEN) tx_done = 1'b1;
          else frame_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data = sh_q;
  assign in_tx   = (state_q == TX);
  assign sdo     = in_tx & tx_q[TX_WIDTH-1];

  // State registers; synchronisers reset to the idle bus levels
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      cs_sync_q  <= '1;
      sck_hist_q <= 1'b0;
      cs_hist_q  <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      tx_q       <= '0;
    end else begin
      sck_sync_q <= sck_sync_d;
      sdi_sync_q <= sdi_sync_d;
      cs_sync_q  <= cs_sync_d;
      sck_hist_q <= sck_hist_d;
      cs_hist_q  <= cs_hist_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: rtl/external_io_v2.sv
// External I/O: job config on SPI0, device config or result
// readout on SPI1, first-winner result capture and core handshake.
module external_io_v2
  import external_io_pkg::*;
#(
  parameter int JOB_CONFIG_WIDTH    = 352,
  parameter int DEVICE_CONFIG_WIDTH = 8,
  parameter int RESULT_DATA_WIDTH   = 40,
  parameter int SYNC_STAGES         = SYNC_STAGES_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sck0,
  input  logic                           sdi0,
  input  logic                           cs0_n,
  input  logic                           sck1,
  input  logic                           sdi1,
  output logic                           sdo1,
  input  logic                           cs1_n,
  output logic [DEVICE_CONFIG_WIDTH-1:0] device_config,
  output logic [JOB_CONFIG_WIDTH-1:0]    job_config,
  input  logic [RESULT_DATA_WIDTH-1:0]   shapool_result,
  input  logic                           shapool_success,
  output logic                           result_valid,
  output logic                           frame_error,
  output logic                           ready
);

  logic [JOB_CONFIG_WIDTH-1:0] rx0_data;
  logic rx0_commit, err0;
  logic spi0_done_unused, spi0_sdo_unused, spi0_tx_unused;
  logic [DEVICE_CONFIG_WIDTH-1:0] rx1_data;
  logic rx1_commit, tx1_done, err1, in_tx1;

  logic [JOB_CONFIG_WIDTH-1:0] job_config_q, job_config_d;
  logic job_valid_q, job_valid_d;
  logic [DEVICE_CONFIG_WIDTH-1:0] device_config_q, device_config_d;
  logic device_valid_q, device_valid_d;
  logic [RESULT_DATA_WIDTH-1:0] result_q, result_d;
  logic result_valid_q, result_valid_d;
  logic frame_error_q, frame_error_d;
  logic ready_q, ready_d;

  spi_slave_frame #(
    .WIDTH(JOB_CONFIG_WIDTH), .TX_EN(1'b0),
    .TX_WIDTH(2), .SYNC_STAGES(SYNC_STAGES)
  ) u_spi0 (
    .clk(clk), .reset(reset),
    .sck(sck0), .sdi(sdi0), .cs_n(cs0_n),
    .tx_req(1'b0), .tx_data(2'b00),
    .rx_data(rx0_data), .rx_commit(rx0_commit),
    .tx_done(spi0_done_unused), .frame_err(err0),
    .sdo(spi0_sdo_unused), .in_tx(spi0_tx_unused)
  );

  spi_slave_frame #(
    .WIDTH(DEVICE_CONFIG_WIDTH), .TX_EN(1'b1),
    .TX_WIDTH(RESULT_DATA_WIDTH), .SYNC_STAGES(SYNC_STAGES)
  ) u_spi1 (
    .clk(clk), .reset(reset),
    .sck(sck1), .sdi(sdi1), .cs_n(cs1_n),
    .tx_req(result_valid_q), .tx_data(result_q),
    .rx_data(rx1_data), .rx_commit(rx1_commit),
    .tx_done(tx1_done), .frame_err(err1),
    .sdo(sdo1), .in_tx(in_tx1)
  );

  // Commit configs, capture the first result, clear it on a full read
  always_comb begin
    job_config_d    = job_config_q;
    job_valid_d     = job_valid_q;
    device_config_d = device_config_q;
    device_valid_d  = device_valid_q;
    result_d        = result_q;
    result_valid_d  = result_valid_q;
    if (rx0_commit) begin
      job_config_d = rx0_data;
      job_valid_d  = 1'b1;
    end
    if (rx1_commit) begin
      device_config_d = rx1_data;
      device_valid_d  = 1'b1;
    end
    if (tx1_done) begin
      result_valid_d = 1'b0;
    end else if (shapool_success && !result_valid_q && !in_tx1) begin
      result_d       = shapool_result;
      result_valid_d = 1'b1;
    end
    frame_error_d = err0 | err1;
    ready_d = job_valid_q & device_valid_q & ~result_valid_q;
  end

  // Committed state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      job_config_q    <= '0;
      job_valid_q     <= 1'b0;
      device_config_q <= '0;
      device_valid_q  <= 1'b0;
      result_q        <= '0;
      result_valid_q  <= 1'b0;
      frame_error_q   <= 1'b0;
      ready_q         <= 1'b0;
    end else begin
      job_config_q    <= job_config_d;
      job_valid_q     <= job_valid_d;
      device_config_q <= device_config_d;
      device_valid_q  <= device_valid_d;
      result_q        <= result_d;
      result_valid_q  <= result_valid_d;
      frame_error_q   <= frame_error_d;
      ready_q         <= ready_d;
    end
  end

  assign job_config    = job_config_q;
  assign device_config = device_config_q;
  assign result_valid  = result_valid_q;
  assign frame_error   = frame_error_q;
  assign ready         = ready_q;

endmodule
